// File: rtl/ps2_device_bytestream.sv
// Device-side PS/2 engine: drives the PS/2 clock, sends device->host frames and
// receives host->device command frames with ACK, behind a byte-stream handshake.
module ps2_device_bytestream #(
    parameter int CLK_RATE   = 50000000,
    parameter int PS2_CLK_HZ = 12500,
    parameter int IDLE_US    = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    output logic       ps2_clk_pd,
    input  logic       ps2_dat_in,
    output logic       ps2_dat_pd,
    input  logic [7:0] bs_data_in,
    input  logic       bs_data_in_valid,
    output logic       bs_data_in_consume,
    output logic [7:0] bs_data_out,
    output logic       bs_data_out_produce,
    output logic       rx_err,
    output logic       busy
);

    localparam int HALF      = CLK_RATE / (2 * PS2_CLK_HZ);
    localparam int QTR       = HALF / 2;
    localparam int IDLE_CYC  = CLK_RATE / 1000000 * IDLE_US;
    localparam int ABORT_CYC = 4;
    localparam int FLUSH_MAX = 16;
    localparam int HW        = $clog2(HALF + 1);
    localparam int IW        = $clog2(IDLE_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_TX, S_RX, S_RX_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   phase_cnt_q, phase_cnt_d;
    logic            phase_low_q, phase_low_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [10:0]     frame_q, frame_d;
    logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
    logic            clk_pd_d, dat_pd_d;
    logic [7:0]      data_out_d;
    logic            consume_d, produce_d, err_d;
    logic [1:0]      clk_sync, dat_sync;

    logic line_clk, line_dat, phase_end, mid_high, cell_end, inhibit, idle_full, parity_ok;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_in};
            dat_sync <= {dat_sync[0], ps2_dat_in};
        end
    end

    assign line_clk  = clk_sync[1];
    assign line_dat  = dat_sync[1];
    assign phase_end = (phase_cnt_q == HW'(HALF - 1));
    assign mid_high  = !phase_low_q && (phase_cnt_q == HW'(QTR));
    assign cell_end  = phase_low_q && phase_end;
    // Released clock takes a few cycles to reach us through the synchroniser,
    // so a low line early in a high phase is not yet a host inhibit.
    assign inhibit   = !phase_low_q && (phase_cnt_q >= HW'(ABORT_CYC)) && !line_clk;
    assign idle_full = (idle_cnt_q >= IW'(IDLE_CYC));
    // After ten shifts: [10]=stop, [9]=parity, [8:1]=data
    assign parity_ok = ^frame_q[9:1];
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q;
        phase_low_d = phase_low_q;
        bit_cnt_d   = bit_cnt_q;
        frame_d     = frame_q;
        idle_cnt_d  = '0;
        clk_pd_d    = ps2_clk_pd;
        dat_pd_d    = ps2_dat_pd;
        data_out_d  = bs_data_out;
        consume_d   = 1'b0;
        produce_d   = 1'b0;
        err_d       = 1'b0;

        if (state_q != S_IDLE) begin
            if (phase_end) begin
                phase_cnt_d = '0;
                phase_low_d = ~phase_low_q;
            end else begin
                phase_cnt_d = phase_cnt_q + HW'(1);
            end
            clk_pd_d = phase_low_d;
        end

        case (state_q)
            S_IDLE: begin
                clk_pd_d    = 1'b0;
                dat_pd_d    = 1'b0;
                phase_cnt_d = '0;
                phase_low_d = 1'b0;
                bit_cnt_d   = '0;
                if (line_clk && line_dat)
                    idle_cnt_d = idle_full ? idle_cnt_q : idle_cnt_q + IW'(1);
                if (line_clk && !line_dat) begin
                    state_d    = S_RX;
                    idle_cnt_d = '0;
                end else if (bs_data_in_valid && idle_full) begin
                    frame_d    = {1'b1, ~^bs_data_in, bs_data_in, 1'b0};
                    state_d    = S_TX;
                    idle_cnt_d = '0;
                end
            end
            S_TX: begin
                if (mid_high) dat_pd_d = ~frame_q[0];
                if (cell_end) begin
                    frame_d   = {1'b0, frame_q[10:1]};
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd10) begin
                        state_d   = S_IDLE;
                        consume_d = 1'b1;
                    end
                end
            end
            S_RX: begin
                if (mid_high) begin
                    if (bit_cnt_q == 5'd10) dat_pd_d = 1'b1;
                    else frame_d = {line_dat, frame_q[10:1]};
                    if (bit_cnt_q == 5'd9 && !line_dat) begin
                        state_d   = S_RX_FLUSH;
                        bit_cnt_d = '0;
                    end
                end
                if (cell_end) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'd10) begin
                        state_d = S_IDLE;
                        if (parity_ok) begin
                            data_out_d = frame_q[8:1];
                            produce_d  = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            S_RX_FLUSH: begin
                // Bad stop bit: keep clocking until the host lets go of data
                if (mid_high && line_dat) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
                if (cell_end) begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                    if (bit_cnt_q == 5'(FLUSH_MAX)) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && inhibit) begin
            state_d    = S_IDLE;
            consume_d  = 1'b0;
            produce_d  = 1'b0;
            err_d      = 1'b0;
            data_out_d = bs_data_out;
        end
        if (state_d == S_IDLE) begin
            clk_pd_d = 1'b0;
            dat_pd_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q             <= S_IDLE;
            phase_cnt_q         <= '0;
            phase_low_q         <= 1'b0;
            bit_cnt_q           <= '0;
            frame_q             <= '0;
            idle_cnt_q          <= '0;
            ps2_clk_pd          <= 1'b0;
            ps2_dat_pd          <= 1'b0;
            bs_data_out         <= '0;
            bs_data_in_consume  <= 1'b0;
            bs_data_out_produce <= 1'b0;
            rx_err              <= 1'b0;
        end else begin
            state_q             <= state_d;
            phase_cnt_q         <= phase_cnt_d;
            phase_low_q         <= phase_low_d;
            bit_cnt_q           <= bit_cnt_d;
            frame_q             <= frame_d;
            idle_cnt_q          <= idle_cnt_d;
            ps2_clk_pd          <= clk_pd_d;
            ps2_dat_pd          <= dat_pd_d;
            bs_data_out         <= data_out_d;
            bs_data_in_consume  <= consume_d;
            bs_data_out_produce <= produce_d;
            rx_err              <= err_d;
        end
    end

endmodule

// File: tb/tb_ps2_device_bytestream.sv
// Directed bench for ps2_device_bytestream: a host model on the open-drain lines
// plus TX/RX scoreboards checked with immediate assertions.
module tb_ps2_device_bytestream;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       host_clk_low = 1'b0;
    logic       host_dat_low = 1'b0;
    logic       ps2_clk_in, ps2_dat_in, ps2_clk_pd, ps2_dat_pd;
    logic [7:0] bs_data_in = 8'h00;
    logic       bs_data_in_valid = 1'b0;
    logic       bs_data_in_consume;
    logic [7:0] bs_data_out;
    logic       bs_data_out_produce, rx_err, busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign ps2_clk_in = ~(ps2_clk_pd | host_clk_low);
    assign ps2_dat_in = ~(ps2_dat_pd | host_dat_low);

    ps2_device_bytestream #(
        .CLK_RATE  (1000000),
        .PS2_CLK_HZ(12500),
        .IDLE_US   (50)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .ps2_clk_in         (ps2_clk_in),
        .ps2_clk_pd         (ps2_clk_pd),
        .ps2_dat_in         (ps2_dat_in),
        .ps2_dat_pd         (ps2_dat_pd),
        .bs_data_in         (bs_data_in),
        .bs_data_in_valid   (bs_data_in_valid),
        .bs_data_in_consume (bs_data_in_consume),
        .bs_data_out        (bs_data_out),
        .bs_data_out_produce(bs_data_out_produce),
        .rx_err             (rx_err),
        .busy               (busy)
    );

    // Line monitor: every device-driven clock fall records the data line
    int   cyc = 0;
    logic prev_cpd = 1'b0;
    logic fall_dat[$];
    int   fall_cyc[$];
    int   n_cons = 0, n_prod = 0, n_err = 0, n_overlap = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ps2_clk_pd && !prev_cpd) begin
            fall_dat.push_back(ps2_dat_in);
            fall_cyc.push_back(cyc);
        end
        prev_cpd <= ps2_clk_pd;
        n_cons <= n_cons + int'(bs_data_in_consume);
        n_prod <= n_prod + int'(bs_data_out_produce);
        n_err  <= n_err + int'(rx_err);
        if (int'(bs_data_in_consume) + int'(bs_data_out_produce) + int'(rx_err) > 1)
            n_overlap <= n_overlap + 1;
    end

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    int         p_cyc;

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_falls(input int n, input int budget);
        int b;
        b = budget;
        while (fall_dat.size() < n && b > 0) begin
            tick(1);
            b--;
        end
        if (fall_dat.size() < n) chk("fall_timeout", fall_dat.size(), n);
    endtask

    task automatic tx_post(input logic [7:0] b);
        exp_tx.push_back(b);
        bs_data_in       = b;
        bs_data_in_valid = 1'b1;
    endtask

    task automatic tx_collect(input string tag, input int c0);
        int         budget;
        logic [10:0] fr;
        logic [7:0]  e;
        bit          sp_ok;
        budget = 3000;
        while (!bs_data_in_consume && budget > 0) begin
            tick(1);
            budget--;
        end
        bs_data_in_valid = 1'b0;
        chk({tag, "_consume_seen"}, bs_data_in_consume, 1);
        chk({tag, "_falls"}, fall_dat.size(), 11);
        fr    = '0;
        sp_ok = 1'b1;
        for (int i = 0; i < 11 && i < fall_dat.size(); i++) fr[i] = fall_dat[i];
        for (int i = 1; i < fall_cyc.size(); i++)
            if (fall_cyc[i] - fall_cyc[i-1] != 80) sp_ok = 1'b0;
        chk({tag, "_spacing80"}, sp_ok, 1);
        e = 8'h00;
        if (exp_tx.size() > 0) e = exp_tx.pop_front();
        chk({tag, "_start"}, fr[0], 0);
        chk({tag, "_data"}, fr[8:1], e);
        chk({tag, "_parity"}, fr[9], ~^e);
        chk({tag, "_stop"}, fr[10], 1);
        tick(1);
        chk({tag, "_busy_after"}, busy, 0);
        tick(2);
        chk({tag, "_consume_once"}, n_cons - c0, 1);
    endtask

    // Host request-to-send followed by a frame clocked by the device
    task automatic host_send(input logic [7:0] b, input logic bad);
        logic [9:0] bits;
        int         budget;
        bits = {1'b1, (~^b) ^ bad, b};
        fall_dat.delete();
        fall_cyc.delete();
        host_clk_low = 1'b1;
        tick(10);
        host_dat_low = 1'b1;
        tick(5);
        host_clk_low = 1'b0;
        budget = 20;
        while (!busy && budget > 0) begin
            tick(1);
            budget--;
        end
        chk("rts_busy", busy, 1);
        tick(2);
        host_dat_low = ~bits[0];
        for (int k = 1; k <= 9; k++) begin
            wait_falls(k, 200);
            tick(5);
            host_dat_low = ~bits[k];
        end
        wait_falls(11, 300);
    endtask

    task automatic rx_check(input string tag, input logic [7:0] b, input logic bad);
        int         p0, e0, budget;
        logic [7:0] d0;
        p0 = n_prod;
        e0 = n_err;
        d0 = bs_data_out;
        if (!bad) exp_rx.push_back(b);
        host_send(b, bad);
        chk({tag, "_ack"}, (fall_dat.size() >= 11) ? fall_dat[10] : 1'b1, 0);
        budget = 200;
        while (!(bs_data_out_produce || rx_err) && budget > 0) begin
            tick(1);
            budget--;
        end
        chk({tag, "_strobe_seen"}, bs_data_out_produce | rx_err, 1);
        if (bs_data_out_produce && exp_rx.size() > 0)
            chk({tag, "_data"}, bs_data_out, exp_rx.pop_front());
        if (bad) chk({tag, "_data_hold"}, bs_data_out, d0);
        p_cyc = cyc;
        tick(3);
        chk({tag, "_produce_cnt"}, n_prod - p0, bad ? 0 : 1);
        chk({tag, "_err_cnt"}, n_err - e0, bad ? 1 : 0);
    endtask

    initial begin
        int c0, budget, rel_cyc;

        // Reset state
        tick(3);
        chk("rst_clk_pd", ps2_clk_pd, 0);
        chk("rst_dat_pd", ps2_dat_pd, 0);
        chk("rst_consume", bs_data_in_consume, 0);
        chk("rst_produce", bs_data_out_produce, 0);
        chk("rst_err", rx_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_out", bs_data_out, 0);
        reset = 1'b1;
        tick(2);

        // Plain transmits
        c0 = n_cons;
        fall_dat.delete(); fall_cyc.delete();
        tx_post(8'h1C);
        tx_collect("tx1c", c0);

        tick(5);
        c0 = n_cons;
        fall_dat.delete(); fall_cyc.delete();
        tx_post(8'h00);
        tx_collect("tx00", c0);

        // Host inhibit during bit 5 aborts, then the byte is retried in full
        tick(5);
        c0 = n_cons;
        fall_dat.delete(); fall_cyc.delete();
        tx_post(8'hF0);
        wait_falls(5, 1000);
        budget = 100;
        while (ps2_clk_pd && budget > 0) begin
            tick(1);
            budget--;
        end
        tick(10);
        host_clk_low = 1'b1;
        tick(10);
        host_clk_low = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_clk_pd", ps2_clk_pd, 0);
        chk("abort_dat_pd", ps2_dat_pd, 0);
        chk("abort_no_consume", n_cons - c0, 0);
        rel_cyc = cyc;
        fall_dat.delete(); fall_cyc.delete();
        tx_collect("txf0_retry", c0);
        chk("retry_idle_gap", (fall_cyc.size() > 0) && (fall_cyc[0] - rel_cyc >= 90), 1);

        // Host -> device commands
        tick(20);
        rx_check("rx_ed_good", 8'hED, 1'b0);
        tick(20);
        rx_check("rx_ed_badpar", 8'hED, 1'b1);

        // RTS wins over a pending transmit; TX follows after a fresh idle gap
        tick(20);
        host_clk_low = 1'b1;
        tick(5);
        c0 = n_cons;
        tx_post(8'h55);
        rx_check("rx_a5_prio", 8'hA5, 1'b0);
        chk("prio_no_consume_during_rx", n_cons - c0, 0);
        fall_dat.delete(); fall_cyc.delete();
        tx_collect("tx55_after_rx", c0);
        chk("prio_idle_gap", (fall_cyc.size() > 0) && (fall_cyc[0] - p_cyc >= 90), 1);

        // Reset in the middle of a transmit
        tick(10);
        c0 = n_cons;
        fall_dat.delete(); fall_cyc.delete();
        tx_post(8'h00);
        wait_falls(3, 1000);
        chk("midtx_dat_pd_pre", ps2_dat_pd, 1);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_clk_pd", ps2_clk_pd, 0);
        chk("midrst_dat_pd", ps2_dat_pd, 0);
        chk("midrst_busy", busy, 0);
        bs_data_in_valid = 1'b0;
        if (exp_tx.size() > 0) void'(exp_tx.pop_front());
        tick(3);
        chk("midrst_no_consume", n_cons - c0, 0);
        reset = 1'b1;
        tick(5);

        chk("strobe_overlap", n_overlap, 0);
        chk("exp_tx_drained", exp_tx.size(), 0);
        chk("exp_rx_drained", exp_rx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
